// File: rtl/mio_bus_ctrl.sv
// Sequenced MIO bus controller: decodes addr[31:28] to one of NUM_SLV slaves, waits on latency+ready, acks.
// Latency: hit ack 2+LAT cycles after accept, miss ack 1 cycle; requests while busy are ignored (no queuing).
module mio_bus_ctrl #(
    parameter int                   NUM_SLV    = 4,
    parameter int                   ADDR_W     = 16,
    parameter logic [NUM_SLV*4-1:0] SLV_REGION = {4'hF, 4'hE, 4'hD, 4'h0},
    parameter logic [NUM_SLV*4-1:0] SLV_LAT    = {(NUM_SLV*4){1'b0}},
    parameter int                   TIMEOUT    = 64,
    parameter int                   CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    output logic                  cpu_busy,
    output logic [NUM_SLV-1:0]    slv_sel,
    output logic                  slv_we,
    output logic [ADDR_W-1:0]     slv_addr,
    output logic [31:0]           slv_wdata,
    input  logic [NUM_SLV*32-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]    slv_rdy
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [NUM_SLV-1:0]  sel_q, sel_d, hit_oh;
    logic                hit;
    logic                slv_we_q, slv_we_d, we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         res_rdata_q, res_rdata_d, cpu_rdata_q, cpu_rdata_d, rdata_sel;
    logic                res_err_q, res_err_d, cpu_err_q, cpu_err_d, cpu_ack_q, cpu_ack_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          lat_sel;
    logic                rdy_sel, done;
    logic                unused_addr;

    assign unused_addr = ^{cpu_addr[1:0], cpu_addr[27:ADDR_W+2]};

    // Descending scan so the lowest matching index wins on duplicate regions.
    always_comb begin
        hit_oh    = '0;
        hit       = 1'b0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (SLV_REGION[i*4 +: 4] == cpu_addr[31:28]) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                hit       = 1'b1;
            end
        end
        lat_sel   = '0;
        rdy_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                lat_sel   = SLV_LAT[i*4 +: 4];
                rdy_sel   = slv_rdy[i];
                rdata_sel = slv_rdata[i*32 +: 32];
            end
        end
    end

    assign done = (cnt_q >= CNT_W'(lat_sel)) && rdy_sel;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        slv_we_d    = 1'b0;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        res_rdata_d = res_rdata_q;
        res_err_d   = res_err_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_err_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr[ADDR_W+1:2];
                    wdata_d = cpu_wdata;
                    if (hit) begin
                        sel_d    = hit_oh;
                        slv_we_d = cpu_we;
                        cnt_d    = '0;
                        state_d  = S_WAIT;
                    end else begin
                        res_err_d   = 1'b1;
                        res_rdata_d = '0;
                        state_d     = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                if (done) begin
                    res_rdata_d = we_q ? 32'd0 : rdata_sel;
                    res_err_d   = 1'b0;
                    sel_d       = '0;
                    state_d     = S_ACK;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_rdata_d = '0;
                    res_err_d   = 1'b1;
                    sel_d       = '0;
                    state_d     = S_ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                // Result is staged so cpu_rdata only changes together with the ack pulse.
                cpu_ack_d   = 1'b1;
                cpu_err_d   = res_err_q;
                cpu_rdata_d = res_rdata_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            slv_we_q    <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            res_rdata_q <= '0;
            res_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_err_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            slv_we_q    <= slv_we_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            res_rdata_q <= res_rdata_d;
            res_err_q   <= res_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_err_q   <= cpu_err_d;
            cpu_ack_q   <= cpu_ack_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_busy  = (state_q != S_IDLE);
    assign slv_sel   = sel_q;
    assign slv_we    = slv_we_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;

endmodule
